// File: rtl/md5_round_ctrl.sv
// md5_round_ctrl: per-block sequencer for the MD5 round register file.
// For each block it collects 16 message words, loads the chaining state,
// then steps 64 rounds and pulses the final add. After that it holds
// digest_vld until the consumer acknowledges.
// Optional feature macro: MD5_CTRL_ABORT_EN. It adds an abort input that
// returns the controller to IDLE and discards the block.
// Handshake: a word is transferred on every cycle where in_vld && in_ready.
// data_vld marks exactly those cycles. in_ready depends only on state,
// never on in_vld.
module md5_round_ctrl #(
  parameter int WORDS  = 16,
  parameter int ROUNDS = 64,
  parameter int IDX_W  = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             first_blk,
  input  logic             in_vld,
`ifdef MD5_CTRL_ABORT_EN
  input  logic             abort,
`endif
  input  logic             digest_ack,
  output logic             in_ready,
  output logic             data_vld,
  output logic             state_vld,
  output logic             sel_iv,
  output logic             round_vld,
  output logic [IDX_W-1:0] round_idx,
  output logic [1:0]       func_sel,
  output logic [3:0]       msg_idx,
  output logic             add_en,
  output logic             digest_vld,
  output logic             busy,
  output logic [2:0]       dbg_state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    INIT  = 3'd2,
    ROUND = 3'd3,
    FINAL = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam int CNT_W = $clog2(WORDS);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   word_cnt_q, word_cnt_d;
  logic [IDX_W-1:0]   round_q, round_d;
  logic               first_q, first_d;
  logic               take_word;

  assign take_word = in_vld && (state_q == LOAD);

  // State, counters and the first-block latch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      word_cnt_q <= '0;
      round_q    <= '0;
      first_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_cnt_q <= word_cnt_d;
      round_q    <= round_d;
      first_q    <= first_d;
    end
  end

  // Next-state logic; the counters wrap back to 0 on their last step.
  always_comb begin
    state_d    = state_q;
    word_cnt_d = word_cnt_q;
    round_d    = round_q;
    first_d    = first_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = LOAD;
          first_d    = first_blk;
          word_cnt_d = '0;
        end
      end
      LOAD: begin
        if (take_word) begin
          word_cnt_d = word_cnt_q + 1'b1;
          if (word_cnt_q == CNT_W'(WORDS - 1)) state_d = INIT;
        end
      end
      INIT: begin
        state_d = ROUND;
        round_d = '0;
      end
      ROUND: begin
        round_d = round_q + 1'b1;
        if (round_q == IDX_W'(ROUNDS - 1)) state_d = FINAL;
      end
      FINAL: state_d = DONE;
      DONE: begin
        if (digest_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
`ifdef MD5_CTRL_ABORT_EN
    if (abort) begin
      state_d    = IDLE;
      word_cnt_d = '0;
      round_d    = '0;
    end
`endif
  end

  // Message-word index g for the current step. All arithmetic is 4-bit,
  // so each result is taken mod 16.
  always_comb begin
    logic [3:0] i;
    i       = round_q[3:0];
    msg_idx = i;
    case (round_q[IDX_W-1:IDX_W-2])
      2'd0: msg_idx = i;
      2'd1: msg_idx = i * 4'd5 + 4'd1;
      2'd2: msg_idx = i * 4'd3 + 4'd5;
      2'd3: msg_idx = i * 4'd7;
      default: msg_idx = i;
    endcase
  end

  // Every output except data_vld is decoded from registered state only.
  assign in_ready   = (state_q == LOAD);
  assign data_vld   = take_word;
  assign state_vld  = (state_q == INIT);
  assign sel_iv     = (state_q == INIT) && first_q;
  assign round_vld  = (state_q == ROUND);
  assign round_idx  = round_q;
  assign func_sel   = round_q[IDX_W-1:IDX_W-2];
  assign add_en     = (state_q == FINAL);
  assign digest_vld = (state_q == DONE);
  assign busy       = (state_q != IDLE);
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_md5_round_ctrl.sv
// Bench for md5_round_ctrl. A block-level timeline model predicts every
// output on every cycle. Literal round/latency values pin that model.
module tb_md5_round_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0, first_blk = 1'b0, in_vld = 1'b0, digest_ack = 1'b0;
`ifdef MD5_CTRL_ABORT_EN
  logic       abort = 1'b0;
`endif
  logic       in_ready, data_vld, state_vld, sel_iv, round_vld;
  logic [5:0] round_idx;
  logic [1:0] func_sel;
  logic [3:0] msg_idx;
  logic       add_en, digest_vld, busy;
  logic [2:0] dbg_state;

  md5_round_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .first_blk(first_blk), .in_vld(in_vld),
`ifdef MD5_CTRL_ABORT_EN
    .abort(abort),
`endif
    .digest_ack(digest_ack), .in_ready(in_ready), .data_vld(data_vld),
    .state_vld(state_vld), .sel_iv(sel_iv), .round_vld(round_vld),
    .round_idx(round_idx), .func_sel(func_sel), .msg_idx(msg_idx),
    .add_en(add_en), .digest_vld(digest_vld), .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A block is a timeline. First come 16 accepted words. Step k counts the
  // cycles after the 16th word: k=0 loads the chaining state, k=1..64 are
  // rounds 0..63, k=65 is the final add, and k>=66 is the digest wait.
  bit m_act = 0, m_first = 0;
  int m_words = 0, m_k = 0;
  int t0 = 0, t_init = -1, t_round = -1, t_final = -1, t_done = -1;
  int dv_cnt = 0, lit_seen = 0;
  bit t_sel = 0;

  int lit_r[8] = '{0, 16, 17, 32, 33, 48, 49, 63};
  int lit_m[8] = '{0, 1, 6, 5, 8, 0, 7, 9};

  function automatic int msg_of(input int r);
    int i;
    i = r % 16;
    case (r / 16)
      0: return i;
      1: return (5 * i + 1) % 16;
      2: return (3 * i + 5) % 16;
      default: return (7 * i) % 16;
    endcase
  endfunction

  // ---------------- scoreboard / compare ----------------
  always @(negedge clk) begin
    logic e_rdy, e_dv, e_sv, e_sel, e_rv, e_add, e_dig, e_busy;
    int   e_ri, e_fs, e_mi;
    e_rdy = 0; e_dv = 0; e_sv = 0; e_sel = 0; e_rv = 0; e_add = 0; e_dig = 0; e_busy = 0;
    e_ri = 0; e_fs = 0; e_mi = 0;
    if (rst_n && m_act) begin
      e_busy = 1;
      if (m_words < 16) begin
        e_rdy = 1; e_dv = in_vld;
      end else if (m_k == 0) begin
        e_sv = 1; e_sel = m_first;
      end else if (m_k <= 64) begin
        e_rv = 1; e_ri = m_k - 1; e_fs = (m_k - 1) / 16; e_mi = msg_of(m_k - 1);
      end else if (m_k == 65) begin
        e_add = 1;
      end else begin
        e_dig = 1;
      end
    end
    check("in_ready", in_ready, e_rdy);
    check("data_vld", data_vld, e_dv);
    check("state_vld", state_vld, e_sv);
    check("sel_iv", sel_iv, e_sel);
    check("round_vld", round_vld, e_rv);
    check("round_idx", round_idx, e_ri);
    check("func_sel", func_sel, e_fs);
    check("msg_idx", msg_idx, e_mi);
    check("add_en", add_en, e_add);
    check("digest_vld", digest_vld, e_dig);
    check("busy", busy, e_busy);

    // hand-computed round indexing points
    if (rst_n && round_vld)
      for (int j = 0; j < 8; j++)
        if (int'(round_idx) == lit_r[j]) begin
          check("msg_idx_lit", msg_idx, lit_m[j]);
          lit_seen++;
        end

    // timeline bookkeeping for the latency checks
    if (data_vld) dv_cnt++;
    if (state_vld && t_init < 0) begin t_init = cyc; t_sel = sel_iv; end
    if (round_vld && t_round < 0) t_round = cyc;
    if (add_en && t_final < 0) t_final = cyc;
    if (digest_vld && t_done < 0) t_done = cyc;

    // advance the model with the inputs the coming edge will sample
    if (!rst_n) m_act = 0;
`ifdef MD5_CTRL_ABORT_EN
    else if (abort) m_act = 0;
`endif
    else if (!m_act) begin
      if (start) begin
        m_act = 1; m_first = first_blk; m_words = 0; m_k = 0;
        t0 = cyc; t_init = -1; t_round = -1; t_final = -1; t_done = -1; dv_cnt = 0;
      end
    end else if (m_words < 16) begin
      if (in_vld) m_words++;
    end else if (m_k < 66) m_k++;
    else if (digest_ack) m_act = 0;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // gap: 0 gapless, 1 every other cycle, 2 random. With noise set, stray
  // start/ack/in_vld are driven where the controller must ignore them.
  task automatic run_block(input bit first, input int gap, input int ack_wait, input bit noise);
    int done_cnt;
    bit fin;
    done_cnt = 0;
    fin = 0;
    start = 1; first_blk = first;
    tick();
    start = 0;
    for (int n = 0; n < 600 && !fin; n++) begin
      if (digest_vld) begin
        digest_ack = (done_cnt >= ack_wait);
        start = noise;
        done_cnt++;
        if (digest_ack) fin = 1;
      end else begin
        digest_ack = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        start      = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        if (noise) first_blk = 1'($urandom_range(0, 1));
      end
      case (gap)
        0: in_vld = 1;
        1: in_vld = n[0];
        default: in_vld = ($urandom_range(0, 3) != 0);
      endcase
      tick();
    end
    start = 0; digest_ack = 0; in_vld = 0;
    check("block_completed", fin, 1);
  endtask

  task automatic check_latency(input bit exp_sel);
    check("lat_init", t_init - t0, 17);
    check("lat_round", t_round - t0, 18);
    check("lat_final", t_final - t0, 82);
    check("lat_done", t_done - t0, 83);
    check("sel_at_init", t_sel, exp_sel);
    check("words_taken", dv_cnt, 16);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int lit0;
    bit found;
    rst_n = 0;
    repeat (3) tick();
    check("rst_busy", busy, 0);
    check("rst_digest_vld", digest_vld, 0);
    check("rst_round_idx", round_idx, 0);
    check("rst_in_ready", in_ready, 0);
    rst_n = 1;
    tick();

    // gapless IV block: latency and round-index pins
    lit0 = lit_seen;
    run_block(1, 0, 0, 0);
    check_latency(1);
    check("lit_points_seen", lit_seen - lit0, 8);

    // alternating in_vld: 16 pulses, INIT strictly after the 16th word
    run_block(1, 1, 0, 0);
    check("gap_words", dv_cnt, 16);
    check("gap_init_late", (t_init - t0) > 17, 1);

    // chained block, ack held off 5 cycles with start pending
    run_block(0, 0, 5, 1);
    check("chain_sel_iv", t_sel, 0);
    check("words_chain", dv_cnt, 16);

    // async reset in the middle of the rounds
    start = 1; first_blk = 1;
    tick();
    start = 0; in_vld = 1;
    found = 0;
    for (int n = 0; n < 200 && !found; n++) begin
      if (round_idx == 6'd30) found = 1;
      else tick();
    end
    check("reached_round30", found, 1);
    #3 rst_n = 0;
    #1;
    check("async_busy", busy, 0);
    check("async_round_vld", round_vld, 0);
    check("async_round_idx", round_idx, 0);
    check("async_in_ready", in_ready, 0);
    in_vld = 0;
    tick(); tick();
    rst_n = 1;
    tick();
    run_block(1, 0, 0, 0);
    check_latency(1);

    // randomized blocks
    for (int b = 0; b < 4; b++) begin
      run_block(1'($urandom_range(0, 1)), 2, int'($urandom_range(0, 3)), 1);
      check("rand_words", dv_cnt, 16);
    end

`ifdef MD5_CTRL_ABORT_EN
    // abort after the 7th word
    start = 1; first_blk = 1;
    tick();
    start = 0; in_vld = 1;
    repeat (7) tick();
    abort = 1;
    tick();
    abort = 0; in_vld = 0;
    check("abort_word_busy", busy, 0);
    repeat (100) tick();
    check("abort_word_no_digest", t_done, -1);
    // abort at round 40
    start = 1;
    tick();
    start = 0; in_vld = 1;
    found = 0;
    for (int n = 0; n < 200 && !found; n++) begin
      if (round_idx == 6'd40) found = 1;
      else tick();
    end
    check("reached_round40", found, 1);
    abort = 1;
    tick();
    abort = 0; in_vld = 0;
    check("abort_round_busy", busy, 0);
    check("abort_round_idx", round_idx, 0);
    repeat (20) tick();
    check("abort_round_no_final", t_final, -1);
    // abort beats start in IDLE
    abort = 1; start = 1;
    tick();
    abort = 0; start = 0;
    check("abort_over_start", busy, 0);
    run_block(1, 0, 0, 0);
    check_latency(1);
`endif

    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
